// File: rtl/bitwise_op_arbiter_pkg.sv
// Shared opcodes and FSM encoding for the
// bitwise operation arbiter slice.
package bitwise_ops_pkg;

  localparam logic [2:0] OP_NOT  = 3'd0;
  localparam logic [2:0] OP_AND  = 3'd1;
  localparam logic [2:0] OP_OR   = 3'd2;
  localparam logic [2:0] OP_XOR  = 3'd3;
  localparam logic [2:0] OP_XNOR = 3'd4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/bitwise_op_arbiter_if.sv
// Client, shared-unit and response bundle
// between requesters and the arbiter.
interface bitwise_op_arbiter_if #(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
);
  localparam int IW = $clog2(NREQ);

  logic [NREQ-1:0]       req;
  logic [3*NREQ-1:0]     op;
  logic [WIDTH*NREQ-1:0] x_in;
  logic [WIDTH*NREQ-1:0] y_in;
  logic [NREQ-1:0]       gnt;
  logic [WIDTH-1:0]      alu_x;
  logic [WIDTH-1:0]      alu_y;
  logic [WIDTH-1:0]      alu_d0;
  logic [WIDTH-1:0]      alu_d1;
  logic [WIDTH-1:0]      alu_d2;
  logic [WIDTH-1:0]      alu_d3;
  logic [WIDTH-1:0]      alu_d4;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IW-1:0]         rsp_id;
  logic [WIDTH-1:0]      rsp_data;
  logic                  rsp_err;
  logic                  busy;

  modport master (
    output req, op, x_in, y_in,
    output alu_d0, alu_d1, alu_d2,
    output alu_d3, alu_d4, rsp_ready,
    input  gnt, alu_x, alu_y,
    input  rsp_valid, rsp_id,
    input  rsp_data, rsp_err, busy
  );

  modport slave (
    input  req, op, x_in, y_in,
    input  alu_d0, alu_d1, alu_d2,
    input  alu_d3, alu_d4, rsp_ready,
    output gnt, alu_x, alu_y,
    output rsp_valid, rsp_id,
    output rsp_data, rsp_err, busy
  );
endinterface

// File: rtl/bitwise_op_arbiter_rr_pick.sv
// Round-robin picker: first set request
// at or after ptr, wrapping.
module rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IW-1:0]   idx,
  output logic            any
);
  always_comb begin
    int j;
    j   = 0;
    gnt = '0;
    idx = '0;
    any = 1'b0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (!any && req[j]) begin
        any    = 1'b1;
        gnt[j] = 1'b1;
        idx    = j[IW-1:0];
      end
    end
  end
endmodule

// File: rtl/bitwise_op_arbiter.sv
// Round-robin front end sharing one bitwise
// unit; IDLE -> EXEC -> RESP per transaction.
module bitwise_op_arbiter
  import bitwise_ops_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int NREQ  = 4
) (
  input logic              clk,
  input logic              rst_n,
  bitwise_op_arbiter_if.slave bus
);
  localparam int IW = $clog2(NREQ);

  state_t            state;
  logic [IW-1:0]     ptr;
  logic [IW-1:0]     id_q;
  logic [2:0]        op_q;
  logic [WIDTH-1:0]  x_q;
  logic [WIDTH-1:0]  y_q;
  logic [NREQ-1:0]   gnt_q;
  logic [NREQ-1:0]   pick_gnt;
  logic [NREQ-1:0]   pick_hot;
  logic [IW-1:0]     pick_idx;
  logic              pick_any;
  logic [2:0]        op_sel;
  logic [WIDTH-1:0]  x_sel;
  logic [WIDTH-1:0]  y_sel;
  logic [WIDTH-1:0]  res_data;
  logic              res_err;
  logic              vld_q;
  logic [WIDTH-1:0]  data_q;
  logic              err_q;
  logic              busy_q;
  logic [IW-1:0]     ptr_nxt;

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req (bus.req),
    .ptr (ptr),
    .gnt (pick_hot),
    .idx (pick_idx),
    .any (pick_any)
  );

  assign pick_gnt = pick_hot;

  always_comb begin
    op_sel = '0;
    x_sel  = '0;
    y_sel  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (pick_gnt[i]) begin
        op_sel = bus.op[3*i +: 3];
        x_sel  = bus.x_in[WIDTH*i +: WIDTH];
        y_sel  = bus.y_in[WIDTH*i +: WIDTH];
      end
    end
  end

  // Illegal opcodes return zero with the error flag.
  always_comb begin
    res_data = '0;
    res_err  = 1'b0;
    case (op_q)
      OP_NOT:  res_data = bus.alu_d0;
      OP_AND:  res_data = bus.alu_d1;
      OP_OR:   res_data = bus.alu_d2;
      OP_XOR:  res_data = bus.alu_d3;
      OP_XNOR: res_data = bus.alu_d4;
      default: res_err  = 1'b1;
    endcase
  end

  assign ptr_nxt = (int'(id_q) == NREQ-1)
                 ? '0 : id_q + 1'b1;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      ptr    <= '0;
      id_q   <= '0;
      op_q   <= '0;
      x_q    <= '0;
      y_q    <= '0;
      gnt_q  <= '0;
      vld_q  <= 1'b0;
      data_q <= '0;
      err_q  <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (pick_any) begin
            id_q   <= pick_idx;
            op_q   <= op_sel;
            x_q    <= x_sel;
            y_q    <= y_sel;
            gnt_q  <= pick_gnt;
            busy_q <= 1'b1;
            state  <= EXEC;
          end
        end
        EXEC: begin
          gnt_q  <= '0;
          data_q <= res_data;
          err_q  <= res_err;
          vld_q  <= 1'b1;
          state  <= RESP;
        end
        RESP: begin
          if (bus.rsp_ready) begin
            vld_q  <= 1'b0;
            busy_q <= 1'b0;
            ptr    <= ptr_nxt;
            state  <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.alu_x     = x_q;
  assign bus.alu_y     = y_q;
  assign bus.rsp_valid = vld_q;
  assign bus.rsp_id    = id_q;
  assign bus.rsp_data  = data_q;
  assign bus.rsp_err   = err_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_bitwise_op_arbiter.sv
// Directed scoreboard bench for the arbiter
// with a behavioural shared bitwise unit.
module tb_bitwise_op_arbiter;
  logic clk;
  logic rst_n;
  int   n_pass;
  int   n_total;

  typedef struct {
    int         id;
    logic [3:0] data;
    logic       err;
  } exp_t;

  exp_t sb[$];

  bitwise_op_arbiter_if #(.WIDTH(4), .NREQ(4)) bus ();

  bitwise_op_arbiter #(.WIDTH(4), .NREQ(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  assign bus.alu_d0 = ~bus.alu_x;
  assign bus.alu_d1 = bus.alu_x & bus.alu_y;
  assign bus.alu_d2 = bus.alu_x | bus.alu_y;
  assign bus.alu_d3 = bus.alu_x ^ bus.alu_y;
  assign bus.alu_d4 = bus.alu_x ^~ bus.alu_y;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic exp_t model(int id, logic [2:0] o,
                                 logic [3:0] x, logic [3:0] y);
    exp_t e;
    e.id  = id;
    e.err = 1'b0;
    case (o)
      3'd0:    e.data = ~x;
      3'd1:    e.data = x & y;
      3'd2:    e.data = x | y;
      3'd3:    e.data = x ^ y;
      3'd4:    e.data = ~(x ^ y);
      default: begin e.data = 4'h0; e.err = 1'b1; end
    endcase
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic drive(int idx, logic [2:0] o,
                       logic [3:0] x, logic [3:0] y);
    bus.op[3*idx +: 3]   = o;
    bus.x_in[4*idx +: 4] = x;
    bus.y_in[4*idx +: 4] = y;
  endtask

  task automatic check_rsp(input string tag);
    exp_t e;
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd1, 32'd0);
    end else begin
      e = sb.pop_front();
      chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd1);
      chk({tag, "_id"}, 32'(bus.rsp_id), 32'(e.id));
      chk({tag, "_data"}, 32'(bus.rsp_data), 32'(e.data));
      chk({tag, "_err"}, 32'(bus.rsp_err), 32'(e.err));
    end
  endtask

  task automatic wait_gnt(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (|bus.gnt) begin ok = 1'b1; break; end
    end
    chk({tag, "_gnt_seen"}, 32'(ok), 32'd1);
  endtask

  task automatic wait_rsp(input string tag);
    bit ok;
    ok = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (bus.rsp_valid) begin ok = 1'b1; break; end
    end
    chk({tag, "_rsp_seen"}, 32'(ok), 32'd1);
  endtask

  // Fixed-latency single transaction with rsp_ready high.
  task automatic run_one(string tag, int idx, logic [2:0] o,
                         logic [3:0] x, logic [3:0] y);
    @(negedge clk);
    drive(idx, o, x, y);
    bus.req = 4'(1 << idx);
    sb.push_back(model(idx, o, x, y));
    @(negedge clk);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'(1 << idx));
    chk({tag, "_alu_x"}, 32'(bus.alu_x), 32'(x));
    chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
    bus.req = '0;
    @(negedge clk);
    chk({tag, "_gnt_off"}, 32'(bus.gnt), 32'd0);
    check_rsp(tag);
    @(negedge clk);
    chk({tag, "_done"}, 32'(bus.rsp_valid), 32'd0);
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_gnt"}, 32'(bus.gnt), 32'd0);
    chk({tag, "_valid"}, 32'(bus.rsp_valid), 32'd0);
    chk({tag, "_id"}, 32'(bus.rsp_id), 32'd0);
    chk({tag, "_data"}, 32'(bus.rsp_data), 32'd0);
    chk({tag, "_err"}, 32'(bus.rsp_err), 32'd0);
    chk({tag, "_alu_x"}, 32'(bus.alu_x), 32'd0);
    chk({tag, "_alu_y"}, 32'(bus.alu_y), 32'd0);
    chk({tag, "_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    exp_t e;
    logic [3:0] hold_d;
    n_pass        = 0;
    n_total       = 0;
    rst_n         = 1'b0;
    bus.req       = '0;
    bus.op        = '0;
    bus.x_in      = '0;
    bus.y_in      = '0;
    bus.rsp_ready = 1'b1;
    repeat (2) @(negedge clk);
    chk_reset("rst");
    rst_n = 1'b1;

    run_one("and0", 0, 3'd1, 4'b1010, 4'b1110);
    run_one("not0", 0, 3'd0, 4'b1010, 4'b1110);
    run_one("or0", 0, 3'd2, 4'b1010, 4'b1110);
    run_one("xor0", 0, 3'd3, 4'b1010, 4'b1110);
    run_one("xnor0", 0, 3'd4, 4'b1010, 4'b1110);

    // Round robin from ptr=0 with all requesting.
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++)
      drive(i, 3'(i), 4'(3*i+5), 4'(9-2*i));
    bus.req = 4'b1111;
    for (int k = 0; k < 5; k++)
      sb.push_back(model(k % 4, 3'(k % 4),
                         4'(3*(k%4)+5), 4'(9-2*(k%4))));
    for (int k = 0; k < 5; k++) begin
      wait_gnt("rr");
      chk("rr_gnt_order", 32'(bus.gnt), 32'(1 << (k % 4)));
      wait_rsp("rr");
      check_rsp("rr");
    end
    @(negedge clk);
    bus.req = '0;
    repeat (3) @(negedge clk);

    // Backpressure while requester 1 waits.
    drive(0, 3'd3, 4'b0110, 4'b0011);
    drive(1, 3'd2, 4'b1000, 4'b0001);
    bus.req = 4'b0001;
    sb.push_back(model(0, 3'd3, 4'b0110, 4'b0011));
    wait_gnt("bp");
    chk("bp_gnt0", 32'(bus.gnt), 32'b0001);
    bus.req       = 4'b0010;
    bus.rsp_ready = 1'b0;
    @(negedge clk);
    e = sb[0];
    check_rsp("bp");
    hold_d = e.data;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk("bp_hold_valid", 32'(bus.rsp_valid), 32'd1);
      chk("bp_hold_data", 32'(bus.rsp_data), 32'(hold_d));
      chk("bp_no_gnt", 32'(bus.gnt), 32'd0);
    end
    bus.rsp_ready = 1'b1;
    sb.push_back(model(1, 3'd2, 4'b1000, 4'b0001));
    wait_gnt("bp1");
    chk("bp_gnt1", 32'(bus.gnt), 32'b0010);
    bus.req = '0;
    wait_rsp("bp1");
    check_rsp("bp1");
    @(negedge clk);

    run_one("ill2", 2, 3'd6, 4'b1111, 4'b0101);
    run_one("leg2", 2, 3'd1, 4'b1111, 4'b0101);

    // Reset in EXEC drops the op and clears ptr.
    run_one("pre0", 0, 3'd2, 4'b0001, 4'b0010);
    @(negedge clk);
    drive(2, 3'd1, 4'b1100, 4'b1010);
    bus.req = 4'b0100;
    @(negedge clk);
    chk("mid_gnt", 32'(bus.gnt), 32'b0100);
    bus.req = '0;
    rst_n   = 1'b0;
    @(negedge clk);
    chk_reset("mid_rst");
    rst_n = 1'b1;
    drive(0, 3'd4, 4'b0011, 4'b0101);
    drive(3, 3'd0, 4'b0000, 4'b0000);
    bus.req = 4'b1001;
    sb.push_back(model(0, 3'd4, 4'b0011, 4'b0101));
    wait_gnt("post");
    chk("post_gnt", 32'(bus.gnt), 32'b0001);
    bus.req = '0;
    wait_rsp("post");
    check_rsp("post");
    chk("sb_drained", 32'(sb.size()), 32'd0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
